// File: rtl/bus_dest_regs_pkg.sv
// Shared core-bus package: bus width, DM write FSM states, destination indices
// for the write-enable vector, and the multi-hot helper used by the conflict check.
package bus_dest_regs_pkg;

  localparam int BUS_W = 16;

  typedef enum logic {
    DM_IDLE = 1'b0,
    DM_REQ  = 1'b1
  } dm_state_t;

  localparam int DST_PC = 0;
  localparam int DST_AR = 1;
  localparam int DST_AC = 2;
  localparam int DST_R  = 3;
  localparam int DST_DR = 4;
  localparam int DST_A  = 5;
  localparam int DST_B  = 6;
  localparam int DST_C  = 7;
  localparam int DST_DM = 8;
  localparam int N_REG  = 8;
  localparam int N_DST  = 9;

  // True when two or more bits of the destination vector are set.
  function automatic logic multi_hot(input logic [N_DST-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/bus_dest_regs_dm_write_port.sv
// Data-memory write port: two-state req/ack FSM with a one-entry holding
// buffer and a sticky overrun flag for writes dropped while a request waits.
module bus_dm_write_port
  import bus_dest_regs_pkg::*;
#(
  parameter int WIDTH = BUS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             ack_i,
  input  logic             err_clr_i,
  output logic             req_o,
  output logic [WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0] wdata_o,
  output logic             overrun_o
);

  dm_state_t        state_q;
  logic             req_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DM_IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      // Clear first so a drop in the same cycle re-sets the flag.
      if (err_clr_i) overrun_q <= 1'b0;
      case (state_q)
        DM_IDLE: begin
          if (wr_en_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            req_q   <= 1'b1;
            state_q <= DM_REQ;
          end
        end
        DM_REQ: begin
          if (ack_i) begin
            if (wr_en_i) begin
              addr_q  <= addr_i;
              wdata_q <= wdata_i;
            end else begin
              req_q   <= 1'b0;
              state_q <= DM_IDLE;
            end
          end else if (wr_en_i) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= DM_IDLE;
        end
      endcase
    end
  end

  assign req_o     = req_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/bus_dest_regs.sv
// Core-bus write endpoint: destination register bank, PC/AR increment, and DM write port.
// Optional BUS_WR_CONFLICT_CHK_EN suppresses all loads when several write enables collide.
module bus_dest_regs
  import bus_dest_regs_pkg::*;
#(
  parameter int WIDTH = BUS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  input  logic             PC_write_en,
  input  logic             AR_write_en,
  input  logic             AC_write_en,
  input  logic             R_write_en,
  input  logic             DR_write_en,
  input  logic             A_write_en,
  input  logic             B_write_en,
  input  logic             C_write_en,
  input  logic             DM_write_en,
  input  logic             PC_inc_en,
  input  logic             AR_inc_en,
  input  logic             err_clr,
  input  logic             dm_ack,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] AR_out,
  output logic [WIDTH-1:0] AC_out,
  output logic [WIDTH-1:0] R_out,
  output logic [WIDTH-1:0] DR_out,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [WIDTH-1:0] C_out,
  output logic             dm_req,
  output logic [WIDTH-1:0] dm_addr,
  output logic [WIDTH-1:0] dm_wdata,
  output logic             dm_overrun,
  output logic             wr_conflict
);

  logic [N_DST-1:0] wr_en_vec;
  logic [N_DST-1:0] ld_en;
  logic [N_REG-1:0] inc_vec;
  logic [WIDTH-1:0] reg_val [N_REG];

  always_comb begin
    wr_en_vec         = '0;
    wr_en_vec[DST_PC] = PC_write_en;
    wr_en_vec[DST_AR] = AR_write_en;
    wr_en_vec[DST_AC] = AC_write_en;
    wr_en_vec[DST_R]  = R_write_en;
    wr_en_vec[DST_DR] = DR_write_en;
    wr_en_vec[DST_A]  = A_write_en;
    wr_en_vec[DST_B]  = B_write_en;
    wr_en_vec[DST_C]  = C_write_en;
    wr_en_vec[DST_DM] = DM_write_en;
    inc_vec           = '0;
    inc_vec[DST_PC]   = PC_inc_en;
    inc_vec[DST_AR]   = AR_inc_en;
  end

`ifdef BUS_WR_CONFLICT_CHK_EN
  logic conflict;
  logic wr_conflict_q;

  assign conflict = multi_hot(wr_en_vec);
  assign ld_en    = conflict ? '0 : wr_en_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wr_conflict_q <= 1'b0;
    else if (conflict) wr_conflict_q <= 1'b1;
    else if (err_clr)  wr_conflict_q <= 1'b0;
  end

  assign wr_conflict = wr_conflict_q;
`else
  assign ld_en       = wr_en_vec;
  assign wr_conflict = 1'b0;
`endif

  // A load takes priority over an increment on the same register.
  for (genvar gi = 0; gi < N_REG; gi++) begin : g_reg
    logic [WIDTH-1:0] val_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           val_q <= '0;
      else if (ld_en[gi])   val_q <= bus;
      else if (inc_vec[gi]) val_q <= val_q + 1'b1;
    end
    assign reg_val[gi] = val_q;
  end

  assign PC_out = reg_val[DST_PC];
  assign AR_out = reg_val[DST_AR];
  assign AC_out = reg_val[DST_AC];
  assign R_out  = reg_val[DST_R];
  assign DR_out = reg_val[DST_DR];
  assign A_out  = reg_val[DST_A];
  assign B_out  = reg_val[DST_B];
  assign C_out  = reg_val[DST_C];

  bus_dm_write_port #(.WIDTH(WIDTH)) u_dm_port (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (ld_en[DST_DM]),
    .addr_i   (reg_val[DST_AR]),
    .wdata_i  (bus),
    .ack_i    (dm_ack),
    .err_clr_i(err_clr),
    .req_o    (dm_req),
    .addr_o   (dm_addr),
    .wdata_o  (dm_wdata),
    .overrun_o(dm_overrun)
  );

endmodule

// File: tb/tb_bus_dest_regs.sv
// Scoreboard bench for bus_dest_regs: expectations are queued with each driven
// cycle and popped against the DUT outputs 1 time unit after the next edge.
module tb_bus_dest_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus;
  logic        PC_write_en, AR_write_en, AC_write_en, R_write_en, DR_write_en;
  logic        A_write_en, B_write_en, C_write_en, DM_write_en;
  logic        PC_inc_en, AR_inc_en, err_clr, dm_ack;
  logic [15:0] PC_out, AR_out, AC_out, R_out, DR_out, A_out, B_out, C_out;
  logic        dm_req, dm_overrun, wr_conflict;
  logic [15:0] dm_addr, dm_wdata;

  always #5 clk = ~clk;

  bus_dest_regs #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .PC_write_en(PC_write_en), .AR_write_en(AR_write_en), .AC_write_en(AC_write_en),
    .R_write_en(R_write_en), .DR_write_en(DR_write_en), .A_write_en(A_write_en),
    .B_write_en(B_write_en), .C_write_en(C_write_en), .DM_write_en(DM_write_en),
    .PC_inc_en(PC_inc_en), .AR_inc_en(AR_inc_en), .err_clr(err_clr), .dm_ack(dm_ack),
    .PC_out(PC_out), .AR_out(AR_out), .AC_out(AC_out), .R_out(R_out), .DR_out(DR_out),
    .A_out(A_out), .B_out(B_out), .C_out(C_out),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_overrun(dm_overrun), .wr_conflict(wr_conflict)
  );

  localparam int O_PC = 0, O_AR = 1, O_AC = 2, O_R = 3, O_DR = 4, O_A = 5, O_B = 6, O_C = 7;
  localparam int O_REQ = 8, O_ADDR = 9, O_WDATA = 10, O_OVR = 11, O_CONF = 12, N_OBS = 13;

  int          n_chk = 0;
  int          n_bad = 0;
  int          step_no = 0;
  int          id_q[$];
  logic [15:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [15:0] observe(input int id);
    case (id)
      O_PC:    return PC_out;
      O_AR:    return AR_out;
      O_AC:    return AC_out;
      O_R:     return R_out;
      O_DR:    return DR_out;
      O_A:     return A_out;
      O_B:     return B_out;
      O_C:     return C_out;
      O_REQ:   return {15'd0, dm_req};
      O_ADDR:  return dm_addr;
      O_WDATA: return dm_wdata;
      O_OVR:   return {15'd0, dm_overrun};
      O_CONF:  return {15'd0, wr_conflict};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input string tag, input logic [15:0] exp);
    id_q.push_back(id);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic push_all_zero(input string tag);
    for (int i = 0; i < N_OBS; i++) push_exp(i, $sformatf("%s_o%0d", tag, i), 16'h0000);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (id_q.size() > 0) begin
      check_val(tag_q.pop_front(), observe(id_q.pop_front()), exp_q.pop_front());
      n++;
    end
    step_no++;
    $display("step %0d: %0d checks, bad so far %0d", step_no, n, n_bad);
  endtask

  task automatic clear_in();
    {PC_write_en, AR_write_en, AC_write_en, R_write_en, DR_write_en} = '0;
    {A_write_en, B_write_en, C_write_en, DM_write_en} = '0;
    {PC_inc_en, AR_inc_en, err_clr, dm_ack} = '0;
    bus = 16'h0000;
  endtask

  // Inputs are already set; expectations already queued.
  task automatic step();
    @(posedge clk);
    #1;
    drain();
    clear_in();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    #12;
    push_all_zero("reset");
    drain();
    @(posedge clk); #1;
    rst_n = 1'b1;

    dm_ack = 1'b1;
    push_exp(O_REQ, "idle_ack_ignored", 16'h0);
    step();

    bus = 16'h1234; AC_write_en = 1'b1;
    push_exp(O_AC, "ac_load", 16'h1234);
    for (int i = 0; i < 8; i++)
      if (i != O_AC) push_exp(i, $sformatf("ac_load_other%0d", i), 16'h0);
    step();

    bus = 16'hFFFF; PC_write_en = 1'b1;
    push_exp(O_PC, "pc_load_ffff", 16'hFFFF);
    step();
    PC_inc_en = 1'b1;
    push_exp(O_PC, "pc_wrap", 16'h0000);
    step();
    bus = 16'h0010; PC_write_en = 1'b1; PC_inc_en = 1'b1;
    push_exp(O_PC, "pc_write_wins", 16'h0010);
    step();

    bus = 16'h0040; AR_write_en = 1'b1;
    push_exp(O_AR, "ar_load", 16'h0040);
    step();

    bus = 16'hBEEF; DM_write_en = 1'b1; AR_inc_en = 1'b1;
    push_exp(O_REQ, "dm_req_rise", 16'h1);
    push_exp(O_ADDR, "dm_addr_pre_edge_ar", 16'h0040);
    push_exp(O_WDATA, "dm_wdata_cap", 16'hBEEF);
    push_exp(O_AR, "ar_inc_same_cycle", 16'h0041);
    step();
    push_exp(O_REQ, "dm_req_hold1", 16'h1);
    push_exp(O_ADDR, "dm_addr_hold1", 16'h0040);
    push_exp(O_WDATA, "dm_wdata_hold1", 16'hBEEF);
    step();
    bus = 16'h5555; DM_write_en = 1'b1;
    push_exp(O_REQ, "dm_req_hold2", 16'h1);
    push_exp(O_WDATA, "overrun_data_kept", 16'hBEEF);
    push_exp(O_OVR, "overrun_set", 16'h1);
    step();
    err_clr = 1'b1;
    push_exp(O_REQ, "dm_req_hold3", 16'h1);
    push_exp(O_WDATA, "dm_wdata_hold3", 16'hBEEF);
    push_exp(O_OVR, "overrun_clr", 16'h0);
    step();
    dm_ack = 1'b1;
    push_exp(O_REQ, "dm_req_fall", 16'h0);
    step();

    for (int v = 1; v <= 3; v++) begin
      dm_ack = 1'b1; DM_write_en = 1'b1; bus = 16'(v);
      push_exp(O_REQ, $sformatf("b2b_req%0d", v), 16'h1);
      push_exp(O_WDATA, $sformatf("b2b_data%0d", v), 16'(v));
      push_exp(O_ADDR, $sformatf("b2b_addr%0d", v), 16'h0041);
      step();
    end
    dm_ack = 1'b1;
    push_exp(O_REQ, "b2b_end", 16'h0);
    step();

    bus = 16'h0007; DM_write_en = 1'b1;
    push_exp(O_WDATA, "cap7", 16'h0007);
    step();
    bus = 16'h0009; DM_write_en = 1'b1; err_clr = 1'b1;
    push_exp(O_OVR, "overrun_set_beats_clr", 16'h1);
    push_exp(O_WDATA, "cap7_kept", 16'h0007);
    step();
    err_clr = 1'b1;
    push_exp(O_OVR, "overrun_clr2", 16'h0);
    step();
    dm_ack = 1'b1;
    push_exp(O_REQ, "req_fall2", 16'h0);
    step();

    bus = 16'h00AA; A_write_en = 1'b1; B_write_en = 1'b1; PC_inc_en = 1'b1;
`ifdef BUS_WR_CONFLICT_CHK_EN
    push_exp(O_A, "conflict_a_kept", 16'h0000);
    push_exp(O_B, "conflict_b_kept", 16'h0000);
    push_exp(O_CONF, "conflict_flag", 16'h1);
`else
    push_exp(O_A, "broadcast_a", 16'h00AA);
    push_exp(O_B, "broadcast_b", 16'h00AA);
    push_exp(O_CONF, "conflict_tied0", 16'h0);
`endif
    push_exp(O_PC, "inc_during_conflict", 16'h0011);
    step();
    err_clr = 1'b1;
    push_exp(O_CONF, "conflict_clr", 16'h0);
    step();

    bus = 16'h0C0C; C_write_en = 1'b1;
    push_exp(O_C, "c_load", 16'h0C0C);
    step();
    bus = 16'h0101; R_write_en = 1'b1;
    push_exp(O_R, "r_load", 16'h0101);
    step();
    bus = 16'h0202; DR_write_en = 1'b1;
    push_exp(O_DR, "dr_load", 16'h0202);
    push_exp(O_R, "r_kept", 16'h0101);
    step();

    bus = 16'h3333; DM_write_en = 1'b1;
    push_exp(O_REQ, "req_before_rst", 16'h1);
    push_exp(O_WDATA, "wdata_before_rst", 16'h3333);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    push_all_zero("async_rst");
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
